// File: rtl/br_predictor_btb.sv
// Branch target buffer with per-entry saturating direction counters.
// Decode looks up a branch PC combinationally and gets a hit, a taken
// prediction and a target in the same cycle. The memory stage writes back
// the resolved outcome one entry per cycle. Updates become visible on the
// cycle after the edge that writes them; there is no same-cycle bypass.
// Two saturating statistics counters track resolved branches and
// mispredictions.
//
// Update port: update_en is a one-cycle qualifier with no back-pressure.
// Whenever update_en=1 at a rising CLK edge with nRST=1, the update is
// consumed at that edge. The block can never stall the pipeline.
module br_predictor_btb #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16,
    localparam int INDEX_W = $clog2(ENTRIES)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [31:0]         lookup_pc,
    output logic                hit,
    output logic                predict,
    output logic [31:0]         br_target_O,
    output logic [INDEX_W-1:0]  index_O,
    input  logic                update_en,
    input  logic [31:0]         update_pc,
    input  logic                br_taken,
    input  logic [31:0]         br_target_I,
    input  logic                mispredict,
    output logic [STAT_W-1:0]   br_count,
    output logic [STAT_W-1:0]   mispredict_count
);

    // Counter encodings. Weakly taken is the MSB-only pattern. Weakly
    // not-taken sits one below it, which collapses to 0 when CTR_W is 1.
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(2 ** (CTR_W - 1) - 1);

    // Table storage
    logic              valid_r  [ENTRIES];
    logic [TAG_W-1:0]  tag_r    [ENTRIES];
    logic [31:0]       target_r [ENTRIES];
    logic [CTR_W-1:0]  ctr_r    [ENTRIES];

    // Address split. pc[1:0] does not take part.
    logic [INDEX_W-1:0] lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;

    assign lookup_idx = lookup_pc[INDEX_W+1:2];
    assign lookup_tag = lookup_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign upd_idx    = update_pc[INDEX_W+1:2];
    assign upd_tag    = update_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign upd_hit    = valid_r[upd_idx] && (tag_r[upd_idx] == upd_tag);

    // Zero-latency lookup against the table contents before this edge
    always_comb begin
        index_O     = lookup_idx;
        hit         = valid_r[lookup_idx] && (tag_r[lookup_idx] == lookup_tag);
        predict     = hit && ctr_r[lookup_idx][CTR_W-1];
        br_target_O = hit ? target_r[lookup_idx] : 32'h0;
    end

    // Table update.
    // On a tag hit: train the counter, and refresh the target on taken.
    // On a miss: allocate on taken only.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= CTR_WEAK_NT;
            end
        end else if (update_en) begin
            if (upd_hit) begin
                if (br_taken) begin
                    if (ctr_r[upd_idx] != CTR_MAX) begin
                        ctr_r[upd_idx] <= ctr_r[upd_idx] + CTR_W'(1);
                    end
                    target_r[upd_idx] <= br_target_I;
                end else if (ctr_r[upd_idx] != '0) begin
                    ctr_r[upd_idx] <= ctr_r[upd_idx] - CTR_W'(1);
                end
            end else if (br_taken) begin
                valid_r[upd_idx]  <= 1'b1;
                tag_r[upd_idx]    <= upd_tag;
                target_r[upd_idx] <= br_target_I;
                ctr_r[upd_idx]    <= CTR_WEAK_T;
            end
        end
    end

    // Saturating statistics counters, advanced once per resolved branch
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            br_count         <= '0;
            mispredict_count <= '0;
        end else if (update_en) begin
            if (br_count != '1) begin
                br_count <= br_count + STAT_W'(1);
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_br_predictor_btb.sv
// Testbench for br_predictor_btb.
// The reference model keeps the table as plain integer arrays and applies
// the lookup/update rules arithmetically. A second instance with STAT_W=2
// exercises saturation of the statistics counters.
module tb_br_predictor_btb;

    localparam int ENTRIES = 8;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int IW      = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] lookup_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        br_taken;
    logic [31:0] br_target_I;
    logic        mispredict;

    logic        hit, predict;
    logic [31:0] br_target_O;
    logic [IW-1:0] index_O;
    logic [15:0] br_count, mispredict_count;

    logic        s2_hit, s2_predict;
    logic [31:0] s2_br_target_O;
    logic [IW-1:0] s2_index_O;
    logic [1:0]  s2_br_count, s2_mispredict_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_valid  [ENTRIES];
    int          m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int          m_br;
    int          m_mp;

    br_predictor_btb #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .STAT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(hit), .predict(predict),
        .br_target_O(br_target_O), .index_O(index_O), .update_en(update_en),
        .update_pc(update_pc), .br_taken(br_taken), .br_target_I(br_target_I),
        .mispredict(mispredict), .br_count(br_count), .mispredict_count(mispredict_count)
    );

    br_predictor_btb #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .STAT_W(2)) dut_s2 (
        .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(s2_hit), .predict(s2_predict),
        .br_target_O(s2_br_target_O), .index_O(s2_index_O), .update_en(update_en),
        .update_pc(update_pc), .br_taken(br_taken), .br_target_I(br_target_I),
        .mispredict(mispredict), .br_count(s2_br_count),
        .mispredict_count(s2_mispredict_count)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int pc_tag(input logic [31:0] pc);
        return int'((pc >> (2 + IW)) % (2 ** TAG_W));
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Compare both instances against the model for the current lookup_pc
    task automatic compare_model();
        int i;
        logic e_hit, e_pred;
        logic [31:0] e_tgt;
        i      = pc_idx(lookup_pc);
        e_hit  = (m_valid[i] != 0) && (m_tag[i] == pc_tag(lookup_pc));
        e_pred = e_hit && (m_ctr[i] >= 2 ** (CTR_W - 1));
        e_tgt  = e_hit ? m_target[i] : 32'h0;
        check("index",     32'(index_O), 32'(i));
        check("hit",       32'(hit), 32'(e_hit));
        check("predict",   32'(predict), 32'(e_pred));
        check("target",    br_target_O, e_tgt);
        check("br_count",  32'(br_count), 32'(min_i(m_br, 65535)));
        check("mp_count",  32'(mispredict_count), 32'(min_i(m_mp, 65535)));
        check("s2_hit",    32'(s2_hit), 32'(e_hit));
        check("s2_br",     32'(s2_br_count), 32'(min_i(m_br, 3)));
        check("s2_mp",     32'(s2_mispredict_count), 32'(min_i(m_mp, 3)));
    endtask

    // Apply the rising-edge rules to the model using the inputs held at the edge
    task automatic model_edge();
        int i, t;
        if (!nRST) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 32'h0;
                m_ctr[k] = 2 ** (CTR_W - 1) - 1;
            end
            m_br = 0;
            m_mp = 0;
        end else if (update_en) begin
            i = pc_idx(update_pc);
            t = pc_tag(update_pc);
            if (m_valid[i] != 0 && m_tag[i] == t) begin
                if (br_taken) begin
                    m_ctr[i] = min_i(m_ctr[i] + 1, 2 ** CTR_W - 1);
                    m_target[i] = br_target_I;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i] = m_ctr[i] - 1;
                end
            end else if (br_taken) begin
                m_valid[i] = 1; m_tag[i] = t; m_target[i] = br_target_I;
                m_ctr[i] = 2 ** (CTR_W - 1);
            end
            if (m_br < 65535) m_br++;
            if (mispredict && m_mp < 65535) m_mp++;
        end
    endtask

    // Driver: set inputs away from the edge, then compare pre-edge outputs
    task automatic drive(input logic rst_n, input logic [31:0] lpc, input logic uen,
                         input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                         input logic mp);
        @(negedge CLK);
        nRST = rst_n; lookup_pc = lpc; update_en = uen; update_pc = upc;
        br_taken = tk; br_target_I = tgt; mispredict = mp;
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
    endtask

    task automatic look(input logic [31:0] lpc);
        drive(1'b1, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                       input logic mp);
        drive(1'b1, upc, 1'b1, upc, tk, tgt, mp);
        tick();
    endtask

    initial begin
        nRST = 1'b0; lookup_pc = 32'h10; update_en = 1'b1; update_pc = 32'h10;
        br_taken = 1'b1; br_target_I = 32'h40; mispredict = 1'b1;
        tick();

        // Reset state; the update held during reset was discarded
        look(32'h0000_0010);
        check("t1_index", 32'(index_O), 32'd4);
        check("t1_hit", 32'(hit), 32'd0);
        check("t1_predict", 32'(predict), 32'd0);
        check("t1_target", br_target_O, 32'h0);
        check("t1_br_count", 32'(br_count), 32'd0);
        tick();

        // Allocate on taken; same-cycle lookup sees old contents
        drive(1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
        check("t5_same_cycle_hit", 32'(hit), 32'd0);
        tick();
        look(32'h10);
        check("t2_hit", 32'(hit), 32'd1);
        check("t2_predict", 32'(predict), 32'd1);
        check("t2_target", br_target_O, 32'h40);
        tick();

        // Counter walk down to 0 and back up to saturation
        for (int n = 0; n < 3; n++) begin
            upd(32'h10, 1'b0, 32'h0, 1'b0);
            look(32'h10);
            check("t3_nt_hit", 32'(hit), 32'd1);
            check("t3_nt_predict", 32'(predict), 32'd0);
            tick();
        end
        for (int n = 0; n < 5; n++) upd(32'h10, 1'b1, 32'h40, 1'b0);
        look(32'h10);
        check("t3_sat_predict", 32'(predict), 32'd1);
        tick();
        upd(32'h10, 1'b0, 32'h0, 1'b0);
        look(32'h10);
        check("t3_sat_then_nt", 32'(predict), 32'd1);
        tick();

        // Aliasing on index 4 with different tags
        look(32'h30);
        check("t4_alias_miss", 32'(hit), 32'd0);
        tick();
        upd(32'h30, 1'b0, 32'h0, 1'b0);
        look(32'h10);
        check("t4_nt_no_alloc", 32'(hit), 32'd1);
        tick();
        upd(32'h30, 1'b1, 32'h80, 1'b0);
        look(32'h30);
        check("t4_replace_hit", 32'(hit), 32'd1);
        check("t4_replace_tgt", br_target_O, 32'h80);
        tick();
        look(32'h10);
        check("t4_evicted", 32'(hit), 32'd0);
        tick();

        // Reset with an update pending
        drive(1'b0, 32'h30, 1'b1, 32'h30, 1'b1, 32'h99, 1'b1);
        tick();
        look(32'h30);
        check("t5_rst_hit", 32'(hit), 32'd0);
        check("t5_rst_br", 32'(br_count), 32'd0);
        check("t5_rst_mp", 32'(mispredict_count), 32'd0);
        tick();

        // Statistics, including 2-bit saturation
        upd(32'h44, 1'b1, 32'h100, 1'b1);
        upd(32'h44, 1'b0, 32'h0, 1'b0);
        upd(32'h44, 1'b1, 32'h100, 1'b1);
        look(32'h44);
        check("t6_br", 32'(br_count), 32'd3);
        check("t6_mp", 32'(mispredict_count), 32'd2);
        tick();
        for (int n = 0; n < 5; n++) upd(32'h48, 1'b1, 32'h200, 1'b1);
        look(32'h48);
        check("t6_s2_br", 32'(s2_br_count), 32'd3);
        check("t6_s2_mp", 32'(s2_mispredict_count), 32'd3);
        check("t6_br16", 32'(br_count), 32'd8);
        tick();

        // Randomized traffic over a small PC range so entries alias often
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] lp, up;
            lp = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 32'h7F));
            up = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 32'h7F));
            if ($urandom_range(0, 3) == 0) lp = up;
            drive(($urandom_range(0, 99) != 0), lp, 1'($urandom_range(0, 1)), up,
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
